// File: rtl/sqrt_pkg.sv
// Shared widths, FSM state type and iteration-count helper for the sqrt datapath blocks.
package sqrt_pkg;

    localparam int unsigned ROOT_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of accumulate cycles needed to retire all root bits.
    function automatic int unsigned iters_for(input int unsigned bits_per_cyc);
        return ROOT_W / bits_per_cyc;
    endfunction

endpackage

// File: rtl/sqrt_rebuild_step.sv
// One shift-add squaring step: adds root shifted by each set multiplier bit of this slice.
module sqrt_rebuild_step
    import sqrt_pkg::*;
#(
    parameter int unsigned BITS = 2
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [ROOT_W-1:0] root,
    input  logic [BITS-1:0]   slice,
    input  logic [CNT_W-1:0]  cnt,
    output logic [DATA_W-1:0] acc_next_c
);

    logic [BITS-1:0] bits_left;

    always_comb begin
        acc_next_c = acc;
        bits_left  = slice;
        for (int j = 0; j < int'(BITS); j++) begin
            if (bits_left[0]) begin
                acc_next_c = acc_next_c + (DATA_W'(root) << (32'(cnt) * BITS + 32'(j)));
            end
            bits_left = bits_left >> 1;
        end
    end

endmodule

// File: rtl/sqrt_rebuild.sv
// Rebuilds the radicand as root*root + remainder with an iterative shift-add squarer.
// Optional SQRT_REBUILD_CHECK_EN adds a registered dataout/tagout mismatch flag.
module sqrt_rebuild
    import sqrt_pkg::*;
#(
    parameter int unsigned BITS_PER_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushin,
    input  logic [ROOT_W-1:0] rootin,
    input  logic [ROOT_W-1:0] remainderin,
    input  logic [DATA_W-1:0] datain,
    output logic              readyout,
    output logic              pushout,
    output logic [DATA_W-1:0] dataout,
    output logic [DATA_W-1:0] tagout,
`ifdef SQRT_REBUILD_CHECK_EN
    output logic              mismatchout,
`endif
    output logic              dropout
);

    localparam int unsigned ITERS = iters_for(BITS_PER_CYC);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ROOT_W-1:0] root, root_nx;
    logic [ROOT_W-1:0] mult, mult_nx;
    logic [DATA_W-1:0] acc, acc_nx;
    logic [DATA_W-1:0] tag, tag_nx;
    logic [DATA_W-1:0] acc_step;

    sqrt_rebuild_step #(
        .BITS(BITS_PER_CYC)
    ) u_step (
        .acc       (acc),
        .root      (root),
        .slice     (mult[BITS_PER_CYC-1:0]),
        .cnt       (cnt),
        .acc_next_c(acc_step)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            root  <= '0;
            mult  <= '0;
            acc   <= '0;
            tag   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            root  <= root_nx;
            mult  <= mult_nx;
            acc   <= acc_nx;
            tag   <= tag_nx;
        end
    end

    // Next-state logic; DONE accepts a new push just like IDLE so ops can chain.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        root_nx  = root;
        mult_nx  = mult;
        acc_nx   = acc;
        tag_nx   = tag;
        case (state)
            IDLE, DONE: begin
                if (pushin) begin
                    root_nx  = rootin;
                    mult_nx  = rootin;
                    tag_nx   = datain;
                    acc_nx   = {{(DATA_W-ROOT_W){1'b0}}, remainderin};
                    cnt_nx   = '0;
                    state_nx = MUL;
                end else begin
                    state_nx = IDLE;
                end
            end
            MUL: begin
                acc_nx  = acc_step;
                mult_nx = mult >> BITS_PER_CYC;
                cnt_nx  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(ITERS - 1)) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs; result and tag are published one cycle after DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readyout <= 1'b1;
            pushout  <= 1'b0;
            dataout  <= '0;
            tagout   <= '0;
            dropout  <= 1'b0;
`ifdef SQRT_REBUILD_CHECK_EN
            mismatchout <= 1'b0;
`endif
        end else begin
            readyout <= (state_nx != MUL);
            pushout  <= (state == DONE);
            if (state == DONE) begin
                dataout <= acc;
                tagout  <= tag;
`ifdef SQRT_REBUILD_CHECK_EN
                mismatchout <= (acc != tag);
`endif
            end
            if (pushin && state == MUL) begin
                dropout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_rebuild.sv
// Self-checking bench for sqrt_rebuild against an arithmetic root*root+remainder model.
// Build with SQRT_REBUILD_CHECK_EN defined to also exercise mismatchout.
module tb_sqrt_rebuild;

    logic        clk;
    logic        rst;
    logic        pushin;
    logic [31:0] rootin;
    logic [31:0] remainderin;
    logic [63:0] datain;
    logic        readyout;
    logic        pushout;
    logic [63:0] dataout;
    logic [63:0] tagout;
    logic        dropout;
`ifdef SQRT_REBUILD_CHECK_EN
    logic        mismatchout;
`endif

    int vectors = 0;
    int miscompares = 0;

    sqrt_rebuild dut (
        .clk        (clk),
        .rst        (rst),
        .pushin     (pushin),
        .rootin     (rootin),
        .remainderin(remainderin),
        .datain     (datain),
        .readyout   (readyout),
        .pushout    (pushout),
        .dataout    (dataout),
        .tagout     (tagout),
`ifdef SQRT_REBUILD_CHECK_EN
        .mismatchout(mismatchout),
`endif
        .dropout    (dropout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model(input logic [31:0] r, input logic [31:0] m);
        return 64'(r) * 64'(r) + 64'(m);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Push one op (inputs set #1 after an edge) and wait for its pushout; lat=999 on timeout.
    task automatic run_op(input logic [31:0] r, input logic [31:0] m, input logic [63:0] d,
                          output int lat);
        rootin = r; remainderin = m; datain = d; pushin = 1'b1;
        lat = 999;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            pushin = 1'b0;
            if (pushout) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] r, input logic [31:0] m);
        logic [63:0] d;
        int lat;
        d = {$urandom, $urandom};
        run_op(r, m, d, lat);
        chk({name, "_latency"}, 64'(lat), 64'd17);
        chk({name, "_data"}, dataout, model(r, m));
        chk({name, "_tag"}, tagout, d);
`ifdef SQRT_REBUILD_CHECK_EN
        chk({name, "_mismatch"}, 64'(mismatchout), 64'(model(r, m) != d));
`endif
    endtask

    initial begin
        int lat;
        int first_e, second_e, npush;
        logic [63:0] first_d, second_d;
        logic sent;
        logic [31:0] r, m;

        rst = 1'b0; pushin = 1'b0; rootin = '0; remainderin = '0; datain = '0;
        #23;
        chk("rst_readyout", 64'(readyout), 64'd1);
        chk("rst_pushout", 64'(pushout), 64'd0);
        chk("rst_dataout", dataout, 64'd0);
        chk("rst_tagout", tagout, 64'd0);
        chk("rst_dropout", 64'(dropout), 64'd0);
`ifdef SQRT_REBUILD_CHECK_EN
        chk("rst_mismatch", 64'(mismatchout), 64'd0);
`endif
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        check_op("single", 32'd3, 32'd2);
        check_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("zero_root", 32'd0, 32'd5);
        for (int i = 0; i < 8; i++) begin
            r = (i < 4) ? 32'($urandom_range(0, 65535)) : $urandom;
            m = $urandom;
            check_op("random", r, m);
        end
        chk("data_held", dataout, model(r, m));

        // Second push issued in the first cycle readyout returns (the DONE cycle).
        rootin = 32'd10; remainderin = 32'd0; datain = 64'd1; pushin = 1'b1;
        sent = 1'b0; first_e = -1; second_e = -1; first_d = '0; second_d = '0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk); #1;
            pushin = 1'b0;
            if (pushout) begin
                if (first_e < 0) begin
                    first_e = e; first_d = dataout;
                end else begin
                    second_e = e; second_d = dataout;
                    break;
                end
            end
            if (!sent && readyout && e > 0) begin
                rootin = 32'd7; remainderin = 32'd1; datain = 64'd2; pushin = 1'b1;
                sent = 1'b1;
            end
        end
        chk("b2b_first_data", first_d, 64'd100);
        chk("b2b_second_data", second_d, 64'd50);
        chk("b2b_spacing", 64'(second_e - first_e), 64'd17);
        chk("b2b_dropout", 64'(dropout), 64'd0);

        // Push while busy: dropped, sticky flag, in-flight op unaffected.
        rootin = 32'd4; remainderin = 32'd0; datain = 64'd3; pushin = 1'b1;
        npush = 0; first_d = '0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            pushin = 1'b0;
            if (pushout) begin
                npush++; first_d = dataout;
            end
            if (e == 4) begin
                chk("drop_readyout", 64'(readyout), 64'd0);
                rootin = 32'd9; remainderin = 32'd9; datain = 64'd4; pushin = 1'b1;
            end
        end
        chk("drop_count", 64'(npush), 64'd1);
        chk("drop_data", first_d, 64'd16);
        chk("drop_flag", 64'(dropout), 64'd1);
        check_op("after_drop", $urandom, $urandom);
        chk("drop_sticky", 64'(dropout), 64'd1);

        // Reset in the middle of an operation.
        rootin = $urandom; remainderin = $urandom; datain = {$urandom, $urandom}; pushin = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            pushin = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("midrst_readyout", 64'(readyout), 64'd1);
        chk("midrst_pushout", 64'(pushout), 64'd0);
        chk("midrst_dataout", dataout, 64'd0);
        chk("midrst_tagout", tagout, 64'd0);
        chk("midrst_dropout", 64'(dropout), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        npush = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk); #1;
            if (pushout) npush++;
        end
        chk("midrst_no_pushout", 64'(npush), 64'd0);
        check_op("after_rst", $urandom, $urandom);

`ifdef SQRT_REBUILD_CHECK_EN
        run_op(32'd5, 32'd3, 64'd28, lat);
        chk("chk_match_data", dataout, 64'd28);
        chk("chk_match", 64'(mismatchout), 64'd0);
        run_op(32'd5, 32'd3, 64'd29, lat);
        chk("chk_mismatch", 64'(mismatchout), 64'd1);
        @(posedge clk); #1;
        chk("chk_mismatch_held", 64'(mismatchout), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
